// File: rtl/maxpool2x2_stream.sv
// rtl/maxpool2x2_stream.sv - streaming 2x2/stride-2 signed max-pool over a raster feature map
// Even rows park pair maxima in a half-width row buffer; odd rows combine with it and emit.
module maxpool2x2_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_WIDTH  = 26,
  parameter int IMG_HEIGHT = 26
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         valid_in,
  output logic                         ready_in,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         valid_out,
  input  logic                         ready_out,
  output logic                         frame_done
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam int BUF_N = IMG_WIDTH / 2;
  localparam int BUF_W = (BUF_N > 1) ? $clog2(BUF_N) : 1;

  if (IMG_WIDTH < 2 || (IMG_WIDTH % 2) != 0 || IMG_HEIGHT < 2 || (IMG_HEIGHT % 2) != 0) begin : g_bad_geometry
    $error("maxpool2x2_stream: IMG_WIDTH and IMG_HEIGHT must be even and at least 2");
  end

  typedef enum logic {
    EVEN_ROW = 1'b0,
    ODD_ROW  = 1'b1
  } row_state_e;

  row_state_e                   state_q, state_d;
  logic [COL_W-1:0]             col_q, col_d;
  logic [ROW_W-1:0]             row_q, row_d;
  logic signed [DATA_WIDTH-1:0] h_q, h_d;
  logic signed [DATA_WIDTH-1:0] out_q, out_d;
  logic                         vld_q, vld_d;
  logic                         last_q, last_d;

  logic signed [DATA_WIDTH-1:0] buf_q [BUF_N];
  logic                         buf_we;
  logic [BUF_W-1:0]             buf_idx;
  logic signed [DATA_WIDTH-1:0] buf_rd;
  logic signed [DATA_WIDTH-1:0] pair_max;
  logic signed [DATA_WIDTH-1:0] quad_max;
  logic                         in_fire;
  logic                         out_fire;
  logic                         col_last;
  logic                         row_last;

  assign ready_in   = !vld_q || ready_out;
  assign in_fire    = valid_in && ready_in;
  assign out_fire   = vld_q && ready_out;
  assign col_last   = (col_q == COL_W'(IMG_WIDTH - 1));
  assign row_last   = (row_q == ROW_W'(IMG_HEIGHT - 1));
  assign buf_idx    = BUF_W'(col_q >> 1);
  assign buf_rd     = buf_q[buf_idx];
  assign pair_max   = (in_data > h_q) ? in_data : h_q;
  assign quad_max   = (buf_rd > pair_max) ? buf_rd : pair_max;

  assign out_data   = out_q;
  assign valid_out  = vld_q;
  assign frame_done = out_fire && last_q && !clear_i;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    h_d     = h_q;
    out_d   = out_q;
    last_d  = last_q;
    vld_d   = vld_q && !out_fire;
    buf_we  = 1'b0;

    if (in_fire) begin
      if (!col_q[0]) begin
        h_d = in_data;
      end else if (state_q == EVEN_ROW) begin
        buf_we = 1'b1;
      end else begin
        // ready_in guarantees any previously held result leaves this same cycle
        out_d  = quad_max;
        vld_d  = 1'b1;
        last_d = row_last && col_last;
      end

      if (col_last) begin
        col_d   = '0;
        row_d   = row_last ? '0 : row_q + 1'b1;
        state_d = (state_q == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    if (clear_i) begin
      col_d   = '0;
      row_d   = '0;
      state_d = EVEN_ROW;
      vld_d   = 1'b0;
      last_d  = 1'b0;
      buf_we  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EVEN_ROW;
      col_q   <= '0;
      row_q   <= '0;
      h_q     <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      h_q     <= h_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
    end
  end

  // Row buffer is deliberately unreset: every entry is rewritten by an even row before use.
  always_ff @(posedge clk_i) begin
    if (buf_we) begin
      buf_q[buf_idx] <= pair_max;
    end
  end

endmodule
